procesador_datos_periferico: RTL and testbench

//  Register-mapped peripheral driven by the data/control generator FSM: a 32-bit control register plus a

---
 rtl/procesador_datos_periferico.sv | 159 +++++++++++++++
 tb/tb_procesador_datos_periferico.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/procesador_datos_periferico.sv
// procesador_datos_periferico
//   Register-mapped peripheral with a 32-bit control register and a
//   2**ADDR_W x 32 data bank. The host loads data words and then writes an
//   instruction with bit0 (start) set. The block rewrites words 0..LAST
//   according to the ONES/CEROS opcode bits, then clears bit0 and pulses done_o.
//
//   Control fields: [0] start/busy, [1] reserved (reads 0), [2] ONES,
//                   [3] CEROS, [11:4] LAST, [31:12] stored only.
//
//   Optional feature macro: STATUS_CONTADOR_EN
//     defined   -> ctrl read bits [31:24] show the number of words processed
//                  (8-bit, saturating). The count is cleared at start and by reset.
//     undefined -> ctrl read bits [31:24] return the last written value.
//
//   Ports:
//     clk_i      in   1   system clock
//     reset_i    in   1   synchronous active-high reset
//     wr_i       in   1   host write strobe
//     reg_sel_i  in   1   0 = control register, 1 = data bank
//     entrada_i  in  32   host write data
//     addr_i     in  32   data bank address (only [ADDR_W-1:0] is used)
//     salida_o   out 32   registered read data
//     done_o     out  1   one-cycle pulse when an operation completes
module procesador_datos_periferico #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_i,
    input  logic        reg_sel_i,
    input  logic [31:0] entrada_i,
    input  logic [31:0] addr_i,
    output logic [31:0] salida_o,
    output logic        done_o
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic [31:0]         ctrl_q;
    logic [31:0]         ctrl_view;
    logic [31:0]         work_q;
    logic [31:0]         op_result;
    logic [ADDR_W-1:0]   k_q;
    logic [ADDR_W-1:0]   end_addr;
    logic [ADDR_W-1:0]   haddr;
    logic [ADDR_W+7:0]   last_ext;
    logic                host_ctrl_we;
    logic                host_data_we;
    logic                fsm_we;
    logic                start;
    logic                unused_bits;

    assign haddr    = addr_i[ADDR_W-1:0];
    // Zero-extend LAST, then keep the low ADDR_W bits: this truncates when
    // ADDR_W < 8 and zero-extends when ADDR_W > 8.
    assign last_ext = {{ADDR_W{1'b0}}, ctrl_q[11:4]};
    assign end_addr = last_ext[ADDR_W-1:0];

`ifdef STATUS_CONTADOR_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            cnt_q <= '0;
        else if (start)
            cnt_q <= '0;
        else if (fsm_we && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
    end

    assign ctrl_view   = {cnt_q, ctrl_q[23:0]};
    assign unused_bits = ^{addr_i[31:ADDR_W], entrada_i[1], last_ext[ADDR_W+7:ADDR_W], ctrl_q[31:24]};
`else
    assign ctrl_view   = ctrl_q;
    assign unused_bits = ^{addr_i[31:ADDR_W], entrada_i[1], last_ext[ADDR_W+7:ADDR_W]};
`endif

    always_comb begin
        op_result = work_q;
        case ({ctrl_q[2], ctrl_q[3]})
            2'b10:   op_result = 32'hFFFF_FFFF;
            2'b01:   op_result = 32'h0000_0000;
            2'b11:   op_result = ~work_q;
            default: op_result = work_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        host_ctrl_we = 1'b0;
        host_data_we = 1'b0;
        fsm_we       = 1'b0;
        start        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_i && !reg_sel_i) begin
                    host_ctrl_we = 1'b1;
                    if (entrada_i[0]) begin
                        start   = 1'b1;
                        state_d = S_READ;
                    end
                end else if (wr_i && reg_sel_i) begin
                    host_data_we = 1'b1;
                end
            end
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                fsm_we  = 1'b1;
                state_d = (k_q == end_addr) ? S_DONE : S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q   <= '0;
            salida_o <= '0;
            done_o   <= 1'b0;
            k_q      <= '0;
            work_q   <= '0;
        end else begin
            salida_o <= reg_sel_i ? mem[haddr] : ctrl_view;
            done_o   <= (state_d == S_DONE);
            if (host_ctrl_we) begin
                ctrl_q <= {entrada_i[31:2], 1'b0, entrada_i[0]};
                k_q    <= '0;
            end
            if (state_q == S_READ)
                work_q <= mem[k_q];
            if (state_q == S_WRITE && k_q != end_addr)
                k_q <= k_q + ADDR_W'(1);
            if (state_q == S_DONE)
                ctrl_q[0] <= 1'b0;
        end
    end

    // The bank has no reset, but writes are suppressed while reset is held so
    // that an aborted operation never commits another word.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (host_data_we)
                mem[haddr] <= entrada_i;
            else if (fsm_we)
                mem[k_q] <= op_result;
        end
    end

endmodule

// File: tb/tb_procesador_datos_periferico.sv
module tb_procesador_datos_periferico;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        wr_i;
    logic        reg_sel_i;
    logic [31:0] entrada_i;
    logic [31:0] addr_i;
    logic [31:0] salida_o;
    logic        done_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [0:255];
    logic [31:0] sb_q [$];

    procesador_datos_periferico #(.ADDR_W(8)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_i      (wr_i),
        .reg_sel_i (reg_sel_i),
        .entrada_i (entrada_i),
        .addr_i    (addr_i),
        .salida_o  (salida_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_op(input logic [31:0] instr, input logic [31:0] w);
        logic ones, ceros;
        ones  = instr[2];
        ceros = instr[3];
        if (ones && !ceros)      return 32'hFFFF_FFFF;
        else if (!ones && ceros) return 32'h0;
        else if (ones && ceros)  return ~w;
        else                     return w;
    endfunction

    // Expected ctrl read-back after a completed operation with instruction w.
    function automatic logic [31:0] exp_ctrl(input logic [31:0] w, input logic [7:0] words);
        logic [31:0] v;
        v = w & 32'hFFFF_FFFC;
`ifdef STATUS_CONTADOR_EN
        v[31:24] = words;
`endif
        return v;
    endfunction

    task automatic host_wr(input logic sel, input logic [31:0] a, input logic [31:0] d);
        reg_sel_i = sel;
        addr_i    = a;
        entrada_i = d;
        wr_i      = 1'b1;
        @(posedge clk_i);
        #1;
        wr_i      = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic sel, input logic [31:0] a, input logic [31:0] exp);
        wr_i      = 1'b0;
        reg_sel_i = sel;
        addr_i    = a;
        sb_q.push_back(exp);
        @(posedge clk_i);
        #1;
        chk(tag, salida_o, sb_q.pop_front());
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 256; i++) begin
            host_wr(1'b1, i, i);
            ref_mem[i] = i;
        end
    endtask

    task automatic model_apply(input logic [31:0] instr);
        for (int i = 0; i <= int'(instr[11:4]); i++)
            ref_mem[i] = model_op(instr, ref_mem[i]);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 256; i++)
            rd_chk(tag, 1'b1, i, ref_mem[i]);
    endtask

    // Waits for the done pulse (bounded), then one more edge so the FSM is idle.
    task automatic wait_done(input string tag);
        int seen;
        seen = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        chk(tag, seen, 1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        reset_i   = 1'b1;
        wr_i      = 1'b0;
        reg_sel_i = 1'b0;
        entrada_i = '0;
        addr_i    = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_salida", salida_o, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        reset_i = 1'b0;
        rd_chk("rst_ctrl", 1'b0, 32'h0, 32'h0);

        // Data write/read and address aliasing
        load_ramp();
        rd_chk("rd_2a", 1'b1, 32'h0000_002A, 32'h2A);
        rd_chk("rd_alias", 1'b1, 32'hFFFF_FF2A, 32'h2A);
        rd_chk("rd_ff", 1'b1, 32'h0000_00FF, 32'hFF);
        rd_chk("ctrl_store", 1'b0, 32'h0, 32'h0);
        host_wr(1'b0, 32'h0, 32'h1234_5FF6);
        rd_chk("ctrl_nostart", 1'b0, 32'h0, exp_ctrl(32'h1234_5FF6, 8'h00));
        rd_chk("nostart_data", 1'b1, 32'h10, 32'h10);

        // ONES over words 0..FD, busy span and done pulse
        host_wr(1'b0, 32'h0, 32'h0000_0FD5);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_cnt++;
            if (salida_o[0]) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        chk("op3_busy", busy_cnt, 509);
        chk("op3_done", done_cnt, 1);
        model_apply(32'h0000_0FD5);
        rd_chk("op3_ctrl", 1'b0, 32'h0, exp_ctrl(32'h0000_0FD5, 8'hFE));
        check_bank("op3_bank");

        // Invert over words 0..FD
        load_ramp();
        host_wr(1'b0, 32'h0, 32'h0000_0FDD);
        wait_done("op4_done");
        model_apply(32'h0000_0FDD);
        rd_chk("op4_w5", 1'b1, 32'h5, ~32'h5);
        rd_chk("op4_wfe", 1'b1, 32'hFE, 32'hFE);
        rd_chk("op4_ctrl", 1'b0, 32'h0, exp_ctrl(32'h0000_0FDD, 8'hFE));
        check_bank("op4_bank");

        // Host writes during busy are ignored
        load_ramp();
        host_wr(1'b0, 32'h0, 32'h0000_0FD5);
        repeat (4) @(posedge clk_i);
        #1;
        host_wr(1'b1, 32'h3, 32'h0000_AAAA);
        host_wr(1'b0, 32'h0, 32'h0);
        wait_done("op5_done");
        model_apply(32'h0000_0FD5);
        rd_chk("op5_ctrl", 1'b0, 32'h0, exp_ctrl(32'h0000_0FD5, 8'hFE));
        check_bank("op5_bank");

        // Reset 100 cycles into an operation
        load_ramp();
        host_wr(1'b0, 32'h0, 32'h0000_0FD5);
        done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_cnt++;
        end
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        chk("op6_salida", salida_o, 32'h0);
        chk("op6_done", {31'b0, done_o}, 32'h0);
        for (int i = 0; i < 50; i++)
            ref_mem[i] = 32'hFFFF_FFFF;
        rd_chk("op6_ctrl", 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_cnt++;
        end
        chk("op6_nodone", done_cnt, 0);
        check_bank("op6_bank");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
